// File: rtl/seg_scan_ctrl_pkg.sv
// rtl/seg_scan_ctrl_pkg.sv - shared constants and blanking helper for the digit scanner
package seg_scan_ctrl_pkg;

  localparam int NDIG            = 4;
  localparam int CLK_DIV_DEFAULT = 50000;

  localparam logic [3:0] ANODE_OFF   = 4'b1111;
  localparam logic [3:0] ANODE_SLOT0 = 4'b1110;

  // Slot k is a leading zero when it and every more significant nibble are zero; slot 0 always shows.
  function automatic logic lz_blanked(input logic [15:0] sh, input logic [1:0] k);
    logic any_nz;
    any_nz = 1'b0;
    for (int j = 0; j < NDIG; j++) begin
      if (j >= int'(k) && sh[4*j +: 4] != 4'h0) begin
        any_nz = 1'b1;
      end
    end
    return (k != 2'd0) && !any_nz;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - load/value inputs and scanned display outputs
interface seg_scan_ctrl_if;

  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        frame_done;

  modport master (
    output load, value, blank_lz,
    input  digit, an, frame_done
  );

  modport slave (
    input  load, value, blank_lz,
    output digit, an, frame_done
  );

endinterface

// File: rtl/seg_scan_ctrl_tick.sv
// rtl/seg_scan_ctrl_tick.sv - slot prescaler, one-cycle tick every DIV clocks
module scan_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit multiplexed display scanner with frame-aligned updates
// and leading-zero blanking; digit is passed raw to the downstream segment decoder.
module seg_scan_ctrl #(
  parameter int CLK_DIV = seg_scan_ctrl_pkg::CLK_DIV_DEFAULT,
  parameter int NDIG    = seg_scan_ctrl_pkg::NDIG
) (
  input logic           clk,
  input logic           rst_n,
  seg_scan_ctrl_if.slave bus
);

  import seg_scan_ctrl_pkg::*;

  localparam logic [1:0] LAST_SLOT = 2'(NDIG - 1);

  logic        tick;
  logic        wrap;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic [3:0]  digit_q, digit_d;
  logic [3:0]  an_q, an_d;
  logic        frame_done_q, frame_done_d;

  scan_tick #(.DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign wrap = tick && (idx_q == LAST_SLOT);

  always_comb begin
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    digit_d      = digit_q;
    an_d         = an_q;
    frame_done_d = 1'b0;

    if (bus.load) begin
      pend_d       = bus.value;
      pend_valid_d = 1'b1;
    end

    // Shadow only changes at the frame boundary so one frame never mixes old and new digits.
    if (wrap) begin
      if (bus.load) begin
        shadow_d = bus.value;
      end else if (pend_valid_q) begin
        shadow_d = pend_q;
      end
      pend_valid_d = 1'b0;
    end

    if (tick) begin
      idx_d        = idx_q + 2'd1;
      digit_d      = shadow_d[{idx_d, 2'b00} +: 4];
      an_d         = (bus.blank_lz && lz_blanked(shadow_d, idx_d)) ? ANODE_OFF
                                                                   : ~(4'b0001 << idx_d);
      frame_done_d = wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= 2'd0;
      shadow_q     <= 16'h0000;
      pend_q       <= 16'h0000;
      pend_valid_q <= 1'b0;
      digit_q      <= 4'h0;
      an_q         <= ANODE_SLOT0;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      digit_q      <= digit_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.digit      = digit_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed and randomized checks of seg_scan_ctrl against a frame-level model
module tb_seg_scan_ctrl;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_ctrl_if dif ();

  seg_scan_ctrl #(.CLK_DIV(DIV), .NDIG(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (dif)
  );

  int checks = 0;
  int errors = 0;

  // Model: e = rising edges since reset release; the frame shows the latest load seen at its first edge.
  int          e         = 0;
  logic [15:0] last_val  = 16'h0;
  logic [15:0] frame_val = 16'h0;
  logic        blank_s   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e         <= 0;
      last_val  <= 16'h0;
      frame_val <= 16'h0;
      blank_s   <= 1'b0;
    end else begin
      e <= e + 1;
      if (dif.load) last_val <= dif.value;
      if ((e + 1) % DIV == 0) blank_s <= dif.blank_lz;
      if ((e + 1) % FRAME == 0) frame_val <= dif.load ? dif.value : last_val;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, e);
    end
  endtask

  always @(negedge clk) begin : cmp
    int         s;
    logic [3:0] ea;
    logic [3:0] ed;
    logic       ef;
    s  = (e / DIV) % 4;
    ed = 4'(frame_val >> (4 * s));
    if (blank_s && s != 0 && (frame_val >> (4 * s)) == 16'h0) ea = 4'hF;
    else ea = ~(4'b0001 << s);
    ef = (e > 0) && (e % FRAME == 0);
    chk("model_an", {12'h0, dif.an}, {12'h0, ea});
    chk("model_digit", {12'h0, dif.digit}, {12'h0, ed});
    chk("model_frame_done", {15'h0, dif.frame_done}, {15'h0, ef});
  end

  task automatic run_to(input int m);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (e % FRAME == m) hit = 1'b1;
    end
    chk("run_to_reached", {15'h0, hit}, 16'h1);
  endtask

  task automatic do_load(input logic [15:0] v);
    dif.load  = 1'b1;
    dif.value = v;
    @(negedge clk);
    dif.load  = 1'b0;
  endtask

  int fdc;

  initial begin
    dif.load     = 1'b0;
    dif.value    = 16'h0;
    dif.blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_an", {12'h0, dif.an}, 16'h000E);
    chk("reset_digit", {12'h0, dif.digit}, 16'h0);
    chk("reset_frame_done", {15'h0, dif.frame_done}, 16'h0);
    rst_n = 1'b1;

    fdc = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (dif.frame_done) fdc++;
      if (i == 3) chk("slot1_an", {12'h0, dif.an}, 16'h000D);
      if (i == 11) chk("slot3_an", {12'h0, dif.an}, 16'h0007);
    end
    chk("frame_done_count", fdc[15:0], 16'd2);

    run_to(6);  do_load(16'h1234);
    run_to(13); chk("old_frame_digit", {12'h0, dif.digit}, 16'h0);
    run_to(1);  chk("new_slot0_digit", {12'h0, dif.digit}, 16'h4);
    run_to(5);  chk("new_slot1_digit", {12'h0, dif.digit}, 16'h3);
    run_to(9);  chk("new_slot2_digit", {12'h0, dif.digit}, 16'h2);
    run_to(13); chk("new_slot3_digit", {12'h0, dif.digit}, 16'h1);

    dif.blank_lz = 1'b1;
    run_to(2);  do_load(16'h0050);
    run_to(1);  chk("lz_slot0_an", {12'h0, dif.an}, 16'h000E);
                chk("lz_slot0_digit", {12'h0, dif.digit}, 16'h0);
    run_to(5);  chk("lz_slot1_an", {12'h0, dif.an}, 16'h000D);
                chk("lz_slot1_digit", {12'h0, dif.digit}, 16'h5);
    run_to(9);  chk("lz_slot2_an", {12'h0, dif.an}, 16'h000F);
    run_to(13); chk("lz_slot3_an", {12'h0, dif.an}, 16'h000F);
    run_to(2);  do_load(16'h0000);
    run_to(1);  chk("zero_slot0_an", {12'h0, dif.an}, 16'h000E);
    run_to(5);  chk("zero_slot1_an", {12'h0, dif.an}, 16'h000F);

    dif.blank_lz = 1'b0;
    run_to(15); do_load(16'hABCD);
    chk("wrap_load_digit", {12'h0, dif.digit}, 16'hD);
    chk("wrap_load_an", {12'h0, dif.an}, 16'h000E);
    chk("wrap_load_frame_done", {15'h0, dif.frame_done}, 16'h1);
    run_to(13); chk("wrap_load_slot3", {12'h0, dif.digit}, 16'hA);

    run_to(3);  do_load(16'h1111); do_load(16'h2222);
    run_to(1);  chk("last_load_slot0", {12'h0, dif.digit}, 16'h2);
    run_to(13); chk("last_load_slot3", {12'h0, dif.digit}, 16'h2);

    run_to(9);  do_load(16'h7777);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_an", {12'h0, dif.an}, 16'h000E);
    chk("async_reset_digit", {12'h0, dif.digit}, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_to(0);  chk("post_reset_digit", {12'h0, dif.digit}, 16'h0);
    run_to(12); chk("post_reset_slot3", {12'h0, dif.digit}, 16'h0);

    for (int i = 0; i < 800; i++) begin
      logic [15:0] mask;
      @(negedge clk);
      case ($urandom_range(0, 4))
        0: mask = 16'hFFFF;
        1: mask = 16'h0FFF;
        2: mask = 16'h00FF;
        3: mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      dif.load  = ($urandom_range(0, 6) == 0);
      dif.value = 16'($urandom) & mask;
      if ($urandom_range(0, 40) == 0) dif.blank_lz = ~dif.blank_lz;
      if ($urandom_range(0, 300) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    dif.load = 1'b0;
    repeat (FRAME) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000: clk cycles per digit slot, legal range 2..2^20.
REQ-002 SHALL have parameter NDIG, fixed at 4: number of multiplexed digits.
REQ-003 Port clk, input, 1: single system clock, rising-edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port load, input, 1: strobe that captures value on the same clk edge.
REQ-006 Port value, input, 16: four hex/BCD nibbles; nibble 0 = bits [3:0] = rightmost digit.
REQ-007 Port blank_lz, input, 1: 1 = suppress leading zeros.
REQ-008 Port digit, output, 4: nibble for the current slot, fed to the downstream 7-segment decoder din.
REQ-009 Port an, output, 4: active-low anode enables, one-hot-low.
REQ-010 Port frame_done, output, 1: one-cycle pulse when slot 3 ends and the scan wraps to slot 0.

Function
REQ-011 Prescaler SHALL count 0..CLK_DIV-1 and wrap, asserting internal tick in the cycle it equals CLK_DIV-1.
REQ-012 On tick, slot index SHALL advance 0->1->2->3->0; it SHALL not change otherwise.
REQ-013 digit, an and frame_done SHALL be registered and SHALL reflect the new slot one clk after tick.
REQ-014 an SHALL be ~(4'b0001 << idx) for a displayed slot, and 4'b1111 for a blanked slot.
REQ-015 digit SHALL be shadow[4*idx+3 : 4*idx]; digit keeps this value even when the slot is blanked.
REQ-016 load=1 SHALL write value into the pending register and set pend_valid=1.
REQ-017 On the wrap tick (idx 3->0), if pend_valid=1, shadow SHALL take pending and pend_valid SHALL clear. This prevents a frame from showing a mix of old and new digits.
REQ-018 If load=1 coincides with the wrap tick, shadow SHALL take value directly and pend_valid SHALL end at 0.
REQ-019 Repeated loads within one frame SHALL overwrite pending; only the last one is shown.
REQ-020 With blank_lz=1, slot k (k=3..1) SHALL be blanked when shadow nibbles k..3 are all zero. Slot 0 SHALL never be blanked. Blanking SHALL be evaluated on shadow, not pending.
REQ-021 With blank_lz=0, no slot SHALL be blanked; blank_lz changes SHALL take effect from the next tick.
REQ-022 frame_done SHALL be 1 for exactly one cycle, coincident with an selecting slot 0.

Reset
REQ-023 rst_n=0 SHALL immediately clear the prescaler, idx, shadow, pending and pend_valid.
REQ-024 During reset, outputs SHALL be an=4'b1110, digit=4'h0 and frame_done=0.
REQ-025 Reset asserted mid-frame or mid-load SHALL discard pending data; after release, scanning SHALL restart at slot 0 with a full CLK_DIV period.

Structure
REQ-026 A shared package SHALL hold NDIG, the default CLK_DIV, and the active-low anode constants ANODE_OFF=4'b1111 and ANODE_SLOT0=4'b1110.
REQ-027 The prescaler SHALL be a separate sub-module scan_tick, with parameter DIV, ports clk, rst_n and tick, and a counter width of $clog2(DIV).
REQ-028 No segment decoding SHALL occur in this block; digit drives the downstream decoder unchanged.

Verification (CLK_DIV=4)
REQ-029 Reset, then run 32 cycles -> an sequence 1110,1101,1011,0111 repeating; each slot lasts exactly 4 cycles; frame_done pulses every 16 cycles.
REQ-030 load value=16'h1234 while blank_lz=0, mid-frame -> old digits finish the frame; the next frame shows digit 4,3,2,1 on slots 0..3.
REQ-031 load value=16'h0050 with blank_lz=1 -> slots 3 and 2 show an=1111; slot 1 shows digit 5; slot 0 shows digit 0. With value=16'h0000, only slot 0 is lit.
REQ-032 Assert load with value=16'hABCD exactly on the wrap tick -> the slot-0 display in the same frame shows digit D and pend_valid=0.
REQ-033 load 16'h1111 then 16'h2222 in the same frame -> the next frame shows 2222 only.
REQ-034 Assert rst_n=0 during slot 2 with a pending load -> an=1110 and digit=0 asynchronously; after release, shadow=0 and the pending value is never displayed.
